mdu_hilo: RTL

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS-style core.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles while the pipeline stalls on busy.
- hi/lo outputs feed directly into the 32-bit 4:1 writeback select mux as the MFHI/MFLO data sources.

---
 rtl/mdu_pkg.sv | 9 +
 rtl/mdu_hilo_if.sv | 15 +
 rtl/mdu_abs_neg.sv | 8 +
 rtl/mdu_hilo.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default datapath width for the HI/LO multiply-divide unit.
package mdu_pkg;
   localparam int MDU_WIDTH = 32;
   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} mdu_state_e;
endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: core-to-MDU request bus plus busy/done status and the HI/LO read ports.
interface mdu_hilo_if import mdu_pkg::*; #(parameter int WIDTH = MDU_WIDTH);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             mthi;
   logic             mtlo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, src_a, src_b, mthi, mtlo, input busy, done, hi, lo);
   modport slave (input start, op, src_a, src_b, mthi, mtlo, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_abs_neg.sv
// mdu_abs_neg: conditional two's-complement, used for operand magnitudes and signed result correction.
module mdu_abs_neg #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] in_v,
   input  logic             neg,
   output logic [WIDTH-1:0] out_v
);
   assign out_v = neg ? -in_v : in_v;
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, WIDTH+1 cycle latency.
// Define MDU_ABORT_EN to add an abort input that flushes an in-flight operation.
module mdu_hilo import mdu_pkg::*; #(parameter int WIDTH = MDU_WIDTH) (
   input logic clk,
   input logic rst_n,
`ifdef MDU_ABORT_EN
   input logic abort,
`endif
   mdu_hilo_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   mdu_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] op_q, op_d;
   logic [WIDTH-1:0] b_q, b_d, rem_q, rem_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
   logic negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0] mul_sum, div_trial;
   logic div_ok, sgn, kill;
   assign sgn = !op_q[0];
   mdu_abs_neg #(WIDTH) u_abs_a (.in_v(bus.src_a), .neg(!bus.op[0] && bus.src_a[WIDTH-1]), .out_v(abs_a));
   mdu_abs_neg #(WIDTH) u_abs_b (.in_v(bus.src_b), .neg(!bus.op[0] && bus.src_b[WIDTH-1]), .out_v(abs_b));
   mdu_abs_neg #(WIDTH) u_fix_q (.in_v(quo_q), .neg(sgn && negq_q), .out_v(quo_fix));
   mdu_abs_neg #(WIDTH) u_fix_r (.in_v(rem_q), .neg(sgn && negr_q), .out_v(rem_fix));
   mdu_abs_neg #(2*WIDTH) u_fix_p (.in_v({rem_q, quo_q}), .neg(sgn && negq_q), .out_v(prod_fix));
   // Multiply keeps {rem,quo} as the product shifting right; divide shifts the dividend out of quo.
   assign mul_sum = {1'b0, rem_q} + {1'b0, quo_q[0] ? b_q : '0};
   assign div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};
   assign div_ok = !div_trial[WIDTH];
`ifdef MDU_ABORT_EN
   assign kill = abort && state_q != S_IDLE;
`else
   assign kill = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      op_d = op_q;
      b_d = b_q;
      rem_d = rem_q;
      quo_d = quo_q;
      negq_d = negq_q;
      negr_d = negr_q;
      dz_d = dz_q;
      hi_d = hi_q;
      lo_d = lo_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: if (bus.start) begin
            state_d = S_CALC;
            cnt_d = CW'(WIDTH-1);
            op_d = bus.op;
            quo_d = abs_a;
            b_d = abs_b;
            rem_d = '0;
            negq_d = bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
            negr_d = bus.src_a[WIDTH-1];
            dz_d = bus.src_b == '0;
         end else begin
            hi_d = bus.mthi ? bus.src_a : hi_q;
            lo_d = bus.mtlo ? bus.src_a : lo_q;
         end
         S_CALC: begin
            rem_d = op_q[1] ? (div_ok ? div_trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}) : mul_sum[WIDTH:1];
            quo_d = op_q[1] ? {quo_q[WIDTH-2:0], div_ok} : {mul_sum[0], quo_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            state_d = cnt_q == '0 ? S_FIX : S_CALC;
         end
         S_FIX: begin
            hi_d = op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_d = op_q[1] ? (dz_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
            state_d = S_IDLE;
            done_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (kill) begin
         state_d = S_IDLE;
         hi_d = hi_q;
         lo_d = lo_q;
         done_d = 1'b0;
      end
      busy_d = state_d != S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         op_q <= '0;
         b_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         dz_q <= 1'b0;
         hi_q <= '0;
         lo_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         op_q <= op_d;
         b_q <= b_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         dz_q <= dz_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi = hi_q;
   assign bus.lo = lo_q;
endmodule
